udp_fragment_slot_manager: RTL and testbench
============================================

Name: udp_fragment_slot_manager

Overview:
- Owns the pool of IPv4 fragment reassembly slots used by the UDP receive path.
- Allocates a slot for a first fragment and publishes per-slot packet ID and empty status to the receive handler.
- Tracks per-slot inactivity timeouts and flushes stale slots.
- Returns a slot to the pool once the downstream consumer has drained a completed datagram.

Parameters:
- FRAGMENT_SLOTS, 2, number of reassembly slots (>=2).
- TIMEOUT_CYCLES, 16'h0FFF, inactivity cycles before an assembling slot is flushed (>=2).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- alloc_request  input  1  request a slot for a new first fragment; single-cycle pulse.
- alloc_packet_id  input  16  IPv4 identification for the request.
- alloc_grant  output  1  one-cycle pulse: slot allocated.
- alloc_fail  output  1  one-cycle pulse: no free slot, or duplicate ID.
- alloc_slot  output  $clog2(FRAGMENT_SLOTS)  granted slot index, valid with alloc_grant.
- touch  input  FRAGMENT_SLOTS  per-slot activity strobe (push_data_valid from handler).
- last  input  FRAGMENT_SLOTS  per-slot final-byte strobe (push_data_last from handler).
- drain_done  input  FRAGMENT_SLOTS  consumer finished reading slot.
- fragment_slot_empty  output  FRAGMENT_SLOTS  1 = slot FREE.
- fragment_slot_packet_id  output  FRAGMENT_SLOTS x 16  ID held by each slot; 0 when FREE.
- slot_flush  output  FRAGMENT_SLOTS  one-cycle pulse to clear the slot FIFO.
- occupancy  output  $clog2(FRAGMENT_SLOTS)+1  count of non-FREE slots.
- timeout_count  output  16  stats (see Optional Feature).
- fail_count  output  16  stats (see Optional Feature).

Behaviour:
- Reset: all slots FREE; fragment_slot_empty all 1s; packet IDs 0; all pulses 0; occupancy 0; timers 0; counters 0.
- Per-slot FSM: FREE -> ASSEMBLING -> COMPLETE -> FREE, or ASSEMBLING -> FLUSH -> FREE.
- FREE -> ASSEMBLING:
  - Request sampled at cycle N.
  - Grant/fail is registered and appears at N+1.
  - Grant goes to the lowest-index FREE slot. That slot's ID is loaded, its timer is loaded with TIMEOUT_CYCLES, and its empty bit clears at N+1.
- Duplicate check: if any non-FREE slot holds alloc_packet_id, assert alloc_fail and allocate nothing.
- No FREE slot: assert alloc_fail.
- A new alloc_request while the previous result is pending is legal; each request is evaluated against state already updated by the prior grant.
- ASSEMBLING:
  - The timer decrements by 1 per cycle.
  - touch[i] reloads it to TIMEOUT_CYCLES.
  - last[i] -> COMPLETE next cycle; the timer stops.
  - Timer reaching 0 -> FLUSH.
- Priority within one cycle: last > touch > expiry.
- FLUSH: slot_flush[i] is high for exactly one cycle; the slot returns to FREE the following cycle. The packet ID is cleared on entry to FREE.
- COMPLETE: waits indefinitely for drain_done[i], then FREE next cycle. The timer is inactive.
- drain_done, touch and last on a slot in the wrong state are ignored.
- Free-and-alloc in the same cycle: the slot becoming FREE is not grantable until the following cycle, because allocation uses registered empty status.
- occupancy is registered and equals the popcount of non-FREE slots after each update.
- reset asserted mid-operation: all slots FREE next cycle; no slot_flush pulse is generated.

Optional Feature:
- Macro: UDP_FRAGMENT_SLOT_STATS_EN.
- Defined:
  - timeout_count increments on each FLUSH entry.
  - fail_count increments on each alloc_fail.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
  - Simultaneous events across slots in one cycle add their total count.
- Undefined: both ports are driven constant 0 and no counter logic is built.

Test Plan:
- alloc_request with ID 0x1234 after reset -> alloc_grant at +1, alloc_slot=0, fragment_slot_empty=2'b10, fragment_slot_packet_id[0]=0x1234, occupancy=1.
- Allocate IDs 0x0001 and 0x0002, then request 0x0003 -> third request gets alloc_fail; fail_count=1 with stats enabled.
- Slot 0 holds 0x0001, request 0x0001 again -> alloc_fail; slot 1 remains empty.
- TIMEOUT_CYCLES=16, allocate, no touch -> slot_flush[0] pulses exactly once at timeout expiry; FREE one cycle later; timeout_count=1.
- Allocate, touch every 10 cycles for 100 cycles, then last[0] -> no flush; slot COMPLETE. drain_done[0] -> empty at +1, packet ID 0.
- last[0] and expiry in the same cycle -> COMPLETE, no slot_flush. Assert reset while both slots are busy -> all empty next cycle, no flush pulses.

Source files
------------

// File: rtl/udp_fragment_slot_manager_if.sv
// udp_fragment_slot_manager_if: allocation, per-slot strobes and status between receive handler and slot manager.
interface udp_fragment_slot_manager_if #(
    parameter int FRAGMENT_SLOTS = 2
);
    localparam int SW = $clog2(FRAGMENT_SLOTS);
    logic                            alloc_request;
    logic [15:0]                     alloc_packet_id;
    logic                            alloc_grant;
    logic                            alloc_fail;
    logic [SW-1:0]                   alloc_slot;
    logic [FRAGMENT_SLOTS-1:0]       touch;
    logic [FRAGMENT_SLOTS-1:0]       last;
    logic [FRAGMENT_SLOTS-1:0]       drain_done;
    logic [FRAGMENT_SLOTS-1:0]       fragment_slot_empty;
    logic [FRAGMENT_SLOTS-1:0][15:0] fragment_slot_packet_id;
    logic [FRAGMENT_SLOTS-1:0]       slot_flush;
    logic [SW:0]                     occupancy;
    logic [15:0]                     timeout_count;
    logic [15:0]                     fail_count;
    modport master (
        output alloc_request, alloc_packet_id, touch, last, drain_done,
        input  alloc_grant, alloc_fail, alloc_slot, fragment_slot_empty,
               fragment_slot_packet_id, slot_flush, occupancy, timeout_count, fail_count
    );
    modport slave (
        input  alloc_request, alloc_packet_id, touch, last, drain_done,
        output alloc_grant, alloc_fail, alloc_slot, fragment_slot_empty,
               fragment_slot_packet_id, slot_flush, occupancy, timeout_count, fail_count
    );
endinterface

// File: rtl/udp_fragment_slot_manager.sv
// udp_fragment_slot_manager: IPv4 fragment reassembly slot pool with per-slot timeout and drain.
// Define UDP_FRAGMENT_SLOT_STATS_EN to build the saturating timeout/fail statistics counters.
module udp_fragment_slot_manager #(
    parameter int          FRAGMENT_SLOTS = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'h0FFF
) (
    input  logic                          clock,
    input  logic                          reset,
    udp_fragment_slot_manager_if.slave    bus
);
    localparam int N  = FRAGMENT_SLOTS;
    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;
    typedef enum logic [1:0] {FREE, ASSEMBLING, COMPLETE, FLUSH} state_t;
    state_t               state_q [N];
    logic [N-1:0][15:0]   id_q;
    logic [15:0]          timer_q [N];
    logic [N-1:0]         empty_q, flush_q, sel, expire;
    logic                 grant_q, fail_q, grant_d, fail_d, found, dup;
    logic [SW-1:0]        slot_q, free_idx;
    logic [CW-1:0]        occ_q, n_rel;
    // Allocation only looks at registered state, so a slot freed this cycle is not grantable yet.
    always_comb begin
        sel = '0;
        found = 1'b0;
        dup = 1'b0;
        free_idx = '0;
        n_rel = '0;
        expire = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q[i] == FREE && !found) begin
                found = 1'b1;
                sel[i] = 1'b1;
                free_idx = SW'(i);
            end
            if (state_q[i] != FREE && id_q[i] == bus.alloc_packet_id) dup = 1'b1;
            expire[i] = state_q[i] == ASSEMBLING && !bus.last[i] && !bus.touch[i] && timer_q[i] == 16'd0;
            if (state_q[i] == FLUSH || (state_q[i] == COMPLETE && bus.drain_done[i])) n_rel = n_rel + CW'(1);
        end
        grant_d = bus.alloc_request && found && !dup;
        fail_d = bus.alloc_request && !grant_d;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= FREE;
                timer_q[i] <= '0;
            end
            id_q <= '0;
            empty_q <= '1;
            flush_q <= '0;
            grant_q <= 1'b0;
            fail_q <= 1'b0;
            slot_q <= '0;
            occ_q <= '0;
        end else begin
            grant_q <= grant_d;
            fail_q <= fail_d;
            if (grant_d) slot_q <= free_idx;
            occ_q <= occ_q + CW'(grant_d) - n_rel;
            flush_q <= expire;
            for (int i = 0; i < N; i++) begin
                case (state_q[i])
                    FREE: if (grant_d && sel[i]) begin
                        state_q[i] <= ASSEMBLING;
                        id_q[i] <= bus.alloc_packet_id;
                        timer_q[i] <= TIMEOUT_CYCLES;
                        empty_q[i] <= 1'b0;
                    end
                    ASSEMBLING: begin
                        if (bus.last[i]) state_q[i] <= COMPLETE;
                        else if (bus.touch[i]) timer_q[i] <= TIMEOUT_CYCLES;
                        else if (expire[i]) state_q[i] <= FLUSH;
                        else timer_q[i] <= timer_q[i] - 16'd1;
                    end
                    COMPLETE: if (bus.drain_done[i]) begin
                        state_q[i] <= FREE;
                        id_q[i] <= '0;
                        timer_q[i] <= '0;
                        empty_q[i] <= 1'b1;
                    end
                    default: begin
                        state_q[i] <= FREE;
                        id_q[i] <= '0;
                        timer_q[i] <= '0;
                        empty_q[i] <= 1'b1;
                    end
                endcase
            end
        end
    end
    assign bus.alloc_grant = grant_q;
    assign bus.alloc_fail = fail_q;
    assign bus.alloc_slot = slot_q;
    assign bus.fragment_slot_empty = empty_q;
    assign bus.fragment_slot_packet_id = id_q;
    assign bus.slot_flush = flush_q;
    assign bus.occupancy = occ_q;
`ifdef UDP_FRAGMENT_SLOT_STATS_EN
    logic [15:0] tmo_q, fail_cnt_q;
    logic [CW-1:0] n_exp;
    logic [16:0] tmo_sum, fail_sum;
    always_comb begin
        n_exp = '0;
        for (int i = 0; i < N; i++) n_exp = n_exp + CW'(expire[i]);
    end
    assign tmo_sum = {1'b0, tmo_q} + 17'(n_exp);
    assign fail_sum = {1'b0, fail_cnt_q} + 17'(fail_d);
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            tmo_q <= tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];
            fail_cnt_q <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
        end
    end
    assign bus.timeout_count = tmo_q;
    assign bus.fail_count = fail_cnt_q;
`else
    assign bus.timeout_count = '0;
    assign bus.fail_count = '0;
`endif
endmodule

// File: tb/tb_udp_fragment_slot_manager.sv
// tb_udp_fragment_slot_manager: directed checks of allocation, duplicate/full fail, timeout flush, drain and reset.
module tb_udp_fragment_slot_manager;
`ifdef UDP_FRAGMENT_SLOT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    int n_flush;
    int at;
    udp_fragment_slot_manager_if #(.FRAGMENT_SLOTS(2)) bus ();
    udp_fragment_slot_manager #(.FRAGMENT_SLOTS(2), .TIMEOUT_CYCLES(16'd16)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.alloc_request = 1'b0;
        bus.alloc_packet_id = '0;
        bus.touch = '0;
        bus.last = '0;
        bus.drain_done = '0;
        step();
        step();
        reset = 1'b0;
    endtask
    task automatic alloc(input logic [15:0] id);
        bus.alloc_request = 1'b1;
        bus.alloc_packet_id = id;
        step();
        bus.alloc_request = 1'b0;
    endtask
    initial begin
        do_reset();
        check("rst_empty", 32'(bus.fragment_slot_empty), 32'h3);
        check("rst_id0", 32'(bus.fragment_slot_packet_id[0]), 32'h0);
        check("rst_occ", 32'(bus.occupancy), 32'h0);
        check("rst_grant", 32'(bus.alloc_grant), 32'h0);
        check("rst_flush", 32'(bus.slot_flush), 32'h0);
        check("rst_tmo", 32'(bus.timeout_count), 32'h0);
        alloc(16'h1234);
        check("a1_grant", 32'(bus.alloc_grant), 32'h1);
        check("a1_slot", 32'(bus.alloc_slot), 32'h0);
        check("a1_empty", 32'(bus.fragment_slot_empty), 32'h2);
        check("a1_id0", 32'(bus.fragment_slot_packet_id[0]), 32'h1234);
        check("a1_occ", 32'(bus.occupancy), 32'h1);
        step();
        check("a1_pulse", 32'(bus.alloc_grant), 32'h0);
        // back-to-back requests until the pool is full
        do_reset();
        alloc(16'h0001);
        check("b1_slot", 32'(bus.alloc_slot), 32'h0);
        bus.alloc_request = 1'b1;
        bus.alloc_packet_id = 16'h0002;
        step();
        check("b2_grant", 32'(bus.alloc_grant), 32'h1);
        check("b2_slot", 32'(bus.alloc_slot), 32'h1);
        check("b2_empty", 32'(bus.fragment_slot_empty), 32'h0);
        bus.alloc_packet_id = 16'h0003;
        step();
        bus.alloc_request = 1'b0;
        check("b3_fail", 32'(bus.alloc_fail), 32'h1);
        check("b3_grant", 32'(bus.alloc_grant), 32'h0);
        check("b3_occ", 32'(bus.occupancy), 32'h2);
        check("b3_failcnt", 32'(bus.fail_count), STATS ? 32'h1 : 32'h0);
        step();
        check("b3_pulse", 32'(bus.alloc_fail), 32'h0);
        // duplicate packet ID
        do_reset();
        alloc(16'h0001);
        alloc(16'h0001);
        check("dup_fail", 32'(bus.alloc_fail), 32'h1);
        check("dup_empty", 32'(bus.fragment_slot_empty), 32'h2);
        check("dup_occ", 32'(bus.occupancy), 32'h1);
        // timeout with no activity: flush 17 cycles after grant, free one cycle later
        do_reset();
        alloc(16'hAAAA);
        n_flush = 0;
        at = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (bus.slot_flush[0]) begin
                n_flush++;
                at = k;
            end
            if (k == 17) check("tmo_busy", 32'(bus.fragment_slot_empty), 32'h2);
            if (k == 18) begin
                check("tmo_free", 32'(bus.fragment_slot_empty), 32'h3);
                check("tmo_id0", 32'(bus.fragment_slot_packet_id[0]), 32'h0);
                check("tmo_occ", 32'(bus.occupancy), 32'h0);
            end
        end
        check("tmo_npulse", 32'(n_flush), 32'h1);
        check("tmo_at", 32'(at), 32'd17);
        check("tmo_cnt", 32'(bus.timeout_count), STATS ? 32'h1 : 32'h0);
        check("tmo_slot1", 32'(bus.slot_flush[1]), 32'h0);
        // periodic touch keeps the slot alive, then last completes it
        do_reset();
        alloc(16'h0BEE);
        n_flush = 0;
        for (int k = 1; k <= 100; k++) begin
            bus.touch = (k % 10 == 0) ? 2'b01 : 2'b00;
            step();
            if (bus.slot_flush != 2'b00) n_flush++;
        end
        bus.touch = '0;
        bus.last = 2'b01;
        step();
        bus.last = '0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.slot_flush != 2'b00) n_flush++;
        end
        check("touch_noflush", 32'(n_flush), 32'h0);
        check("cmpl_empty", 32'(bus.fragment_slot_empty), 32'h2);
        check("cmpl_id0", 32'(bus.fragment_slot_packet_id[0]), 32'h0BEE);
        // drain and allocate together: the draining slot is not reusable yet
        bus.drain_done = 2'b01;
        alloc(16'h0C0C);
        bus.drain_done = '0;
        check("drain_grant", 32'(bus.alloc_grant), 32'h1);
        check("drain_slot", 32'(bus.alloc_slot), 32'h1);
        check("drain_empty", 32'(bus.fragment_slot_empty), 32'h1);
        check("drain_id0", 32'(bus.fragment_slot_packet_id[0]), 32'h0);
        check("drain_id1", 32'(bus.fragment_slot_packet_id[1]), 32'h0C0C);
        check("drain_occ", 32'(bus.occupancy), 32'h1);
        // last on the expiry cycle wins over the flush
        do_reset();
        alloc(16'h5555);
        for (int k = 0; k < 16; k++) step();
        bus.last = 2'b01;
        step();
        bus.last = '0;
        check("race_flush", 32'(bus.slot_flush), 32'h0);
        check("race_empty", 32'(bus.fragment_slot_empty), 32'h2);
        step();
        check("race_flush2", 32'(bus.slot_flush), 32'h0);
        check("race_occ", 32'(bus.occupancy), 32'h1);
        alloc(16'h6666);
        check("busy_empty", 32'(bus.fragment_slot_empty), 32'h0);
        reset = 1'b1;
        step();
        check("mid_rst_empty", 32'(bus.fragment_slot_empty), 32'h3);
        check("mid_rst_flush", 32'(bus.slot_flush), 32'h0);
        check("mid_rst_occ", 32'(bus.occupancy), 32'h0);
        check("mid_rst_id1", 32'(bus.fragment_slot_packet_id[1]), 32'h0);
        reset = 1'b0;
        step();
        check("post_rst_flush", 32'(bus.slot_flush), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
